// File: rtl/arm_shift_pipe.sv
// Pipelined ARM barrel shifter: a decode register followed by PIPE_STAGES rank stages.
// Optional flag outputs (zero_out, neg_out) are enabled with ARM_SHIFT_PIPE_FLAGS_EN.
module arm_shift_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int AMOUNT_WIDTH = 8,
    parameter int PIPE_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    imm_mode,
    input  logic [1:0]              shift_op,
    input  logic [DATA_WIDTH-1:0]   shift_in,
    input  logic [AMOUNT_WIDTH-1:0] shift_amount,
    input  logic                    carry_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   shift_out,
    output logic                    carry_out
`ifdef ARM_SHIFT_PIPE_FLAGS_EN
    ,
    output logic                    zero_out,
    output logic                    neg_out
`endif
);

    localparam int W   = DATA_WIDTH;
    localparam int R   = $clog2(W);
    localparam int RPS = (R + PIPE_STAGES - 1) / PIPE_STAGES;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;

    logic                           w_adv;
    logic [R-1:0]                   w_k;
    logic [R-1:0]                   w_idx_l;
    logic [R-1:0]                   w_idx_r;
    logic                           w_a_lt;
    logic                           w_a_eq;
    logic                           w_plain;
    logic [W-1:0]                   w_dec_data;
    logic [R-1:0]                   w_dec_amt;
    logic                           w_dec_carry;
    logic [PIPE_STAGES-1:0][W-1:0]  w_data_nxt;

    logic [PIPE_STAGES:0]           r_vld;
    logic [PIPE_STAGES:0][W-1:0]    r_data;
    logic [PIPE_STAGES:0]           r_carry;
    logic [PIPE_STAGES-1:0][R-1:0]  r_amt;
    logic [PIPE_STAGES-1:0][1:0]    r_op;

    function automatic logic [W-1:0] f_rank(input logic [W-1:0] d, input logic [1:0] op,
                                            input int sh);
        logic [W-1:0] res;
        case (op)
            OP_LSL:  res = d << sh;
            OP_LSR:  res = d >> sh;
            OP_ASR:  res = $unsigned($signed(d) >>> sh);
            default: res = (d >> sh) | (d << (W - sh));
        endcase
        return res;
    endfunction

    assign w_adv     = out_ready || !out_valid;
    assign in_ready  = w_adv && !rst;
    assign out_valid = r_vld[PIPE_STAGES];
    assign shift_out = r_data[PIPE_STAGES];
    assign carry_out = r_carry[PIPE_STAGES];

    assign w_k     = shift_amount[R-1:0];
    assign w_idx_l = R'(0) - w_k;
    assign w_idx_r = w_k - R'(1);
    assign w_a_lt  = shift_amount < AMOUNT_WIDTH'(W);
    assign w_a_eq  = shift_amount == AMOUNT_WIDTH'(W);

    // Special cases are folded into the operand here, so the ranks only ever see a plain shift.
    always_comb begin
        w_dec_data  = shift_in;
        w_dec_amt   = '0;
        w_dec_carry = carry_in;
        w_plain     = 1'b0;
        if (imm_mode) begin
            if (w_k != '0) begin
                w_plain = 1'b1;
            end else begin
                case (shift_op)
                    OP_LSL: begin
                        w_dec_data = shift_in;
                    end
                    OP_LSR: begin
                        w_dec_data  = '0;
                        w_dec_carry = shift_in[W-1];
                    end
                    OP_ASR: begin
                        w_dec_data  = {W{shift_in[W-1]}};
                        w_dec_carry = shift_in[W-1];
                    end
                    default: begin
                        w_dec_data  = {carry_in, shift_in[W-1:1]};
                        w_dec_carry = shift_in[0];
                    end
                endcase
            end
        end else if (shift_amount != '0) begin
            if (shift_op == 2'b11) begin
                if (w_k != '0) w_plain = 1'b1;
                else           w_dec_carry = shift_in[W-1];
            end else if (w_a_lt) begin
                w_plain = 1'b1;
            end else begin
                case (shift_op)
                    OP_LSL: begin
                        w_dec_data  = '0;
                        w_dec_carry = w_a_eq & shift_in[0];
                    end
                    OP_LSR: begin
                        w_dec_data  = '0;
                        w_dec_carry = w_a_eq & shift_in[W-1];
                    end
                    default: begin
                        w_dec_data  = {W{shift_in[W-1]}};
                        w_dec_carry = shift_in[W-1];
                    end
                endcase
            end
        end
        if (w_plain) begin
            w_dec_amt   = w_k;
            w_dec_carry = (shift_op == OP_LSL) ? shift_in[w_idx_l] : shift_in[w_idx_r];
        end
    end

    // Stage s applies ranks s*RPS .. s*RPS+RPS-1, LSB ranks first.
    always_comb begin
        for (int s = 0; s < PIPE_STAGES; s++) begin
            w_data_nxt[s] = r_data[s];
            for (int i = 0; i < R; i++) begin
                if ((i / RPS) == s && r_amt[s][i])
                    w_data_nxt[s] = f_rank(w_data_nxt[s], r_op[s], 1 << i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld   <= '0;
            r_data  <= '0;
            r_carry <= '0;
            r_amt   <= '0;
            r_op    <= '0;
        end else if (w_adv) begin
            r_vld      <= {r_vld[PIPE_STAGES-1:0], in_valid};
            r_data[0]  <= w_dec_data;
            r_carry[0] <= w_dec_carry;
            r_amt[0]   <= w_dec_amt;
            r_op[0]    <= shift_op;
            for (int s = 0; s < PIPE_STAGES; s++) begin
                r_data[s+1]  <= w_data_nxt[s];
                r_carry[s+1] <= r_carry[s];
            end
            for (int s = 1; s < PIPE_STAGES; s++) begin
                r_amt[s] <= r_amt[s-1];
                r_op[s]  <= r_op[s-1];
            end
        end
    end

`ifdef ARM_SHIFT_PIPE_FLAGS_EN
    logic r_zero;
    logic r_neg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (w_adv) begin
            r_zero <= (w_data_nxt[PIPE_STAGES-1] == '0);
            r_neg  <= w_data_nxt[PIPE_STAGES-1][W-1];
        end
    end

    assign zero_out = r_zero;
    assign neg_out  = r_neg;
`endif

endmodule

// File: tb/tb_arm_shift_pipe.sv
// Scoreboard bench for arm_shift_pipe: directed cases, backpressure, reset, randomised ops.
// Flag checks are compiled in when ARM_SHIFT_PIPE_FLAGS_EN is defined.
module tb_arm_shift_pipe;
    localparam int W  = 32;
    localparam int AW = 8;
    localparam int P  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          imm_mode = 1'b0;
    logic [1:0]    shift_op = 2'b00;
    logic [W-1:0]  shift_in = '0;
    logic [AW-1:0] shift_amount = '0;
    logic          carry_in = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  shift_out;
    logic          carry_out;
`ifdef ARM_SHIFT_PIPE_FLAGS_EN
    logic          zero_out;
    logic          neg_out;
`endif

    arm_shift_pipe #(.DATA_WIDTH(W), .AMOUNT_WIDTH(AW), .PIPE_STAGES(P)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .imm_mode(imm_mode), .shift_op(shift_op), .shift_in(shift_in),
        .shift_amount(shift_amount), .carry_in(carry_in), .out_valid(out_valid),
        .out_ready(out_ready), .shift_out(shift_out), .carry_out(carry_out)
`ifdef ARM_SHIFT_PIPE_FLAGS_EN
        , .zero_out(zero_out), .neg_out(neg_out)
`endif
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [32:0] sb_q[$];
    string       tag_q[$];
    bit          tog_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model written straight from the operation table; returns {carry, data}.
    function automatic logic [32:0] model(input bit imm, input logic [1:0] op,
                                          input logic [31:0] d, input int a_in, input bit cin);
        int          a;
        int          m;
        logic [31:0] r;
        logic [32:0] res;
        a   = a_in;
        res = {cin, d};
        if (imm) begin
            a = a_in % 32;
            if (a == 0 && (op == 2'd1 || op == 2'd2)) a = 32;
        end
        if (imm && a == 0 && op == 2'd3) begin
            res = {d[0], cin, d[31:1]};
        end else if (a != 0) begin
            case (op)
                2'd0: begin
                    if (a < 32) begin r = d << a; res = {d[32-a], r}; end
                    else if (a == 32) res = {d[0], 32'h0};
                    else res = 33'h0;
                end
                2'd1: begin
                    if (a < 32) begin r = d >> a; res = {d[a-1], r}; end
                    else if (a == 32) res = {d[31], 32'h0};
                    else res = 33'h0;
                end
                2'd2: begin
                    if (a < 32) begin r = $unsigned($signed(d) >>> a); res = {d[a-1], r}; end
                    else res = {d[31], {32{d[31]}}};
                end
                default: begin
                    m = a % 32;
                    if (m == 0) res = {d[31], d};
                    else begin r = (d >> m) | (d << (32 - m)); res = {r[31], r}; end
                end
            endcase
        end
        return res;
    endfunction

    always @(posedge clk) begin
        #1;
        if (tog_en) out_ready = !out_ready;
    end

    logic [31:0] prev_data;
    logic        prev_c;
    bit          prev_stall = 1'b0;
    logic [32:0] e;
    string       t;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_data", shift_out, prev_data);
                chk("stall_hold_carry", carry_out, prev_c);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out", out_valid, 0);
                end else begin
                    e = sb_q.pop_front();
                    t = tag_q.pop_front();
                    chk({t, "_data"}, shift_out, e[31:0]);
                    chk({t, "_carry"}, carry_out, e[32]);
`ifdef ARM_SHIFT_PIPE_FLAGS_EN
                    chk({t, "_zero"}, zero_out, (e[31:0] == 32'h0));
                    chk({t, "_neg"}, neg_out, e[31]);
`endif
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = shift_out;
            prev_c     = carry_out;
        end
    end

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic send(input bit imm, input logic [1:0] op, input logic [31:0] d, input int a,
                        input bit cin, input logic [32:0] exp, input string tag);
        int n = 0;
        in_valid     = 1'b1;
        imm_mode     = imm;
        shift_op     = op;
        shift_in     = d;
        shift_amount = a[7:0];
        carry_in     = cin;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            chk({tag, "_accept_timeout"}, in_ready, 1);
        end else begin
            sb_q.push_back(exp);
            tag_q.push_back(tag);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb_q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain"}, sb_q.size(), 0);
    endtask

    int          amts[8] = '{0, 1, 31, 32, 33, 63, 64, 255};
    bit          r_imm;
    bit          r_cin;
    logic [1:0]  r_op;
    logic [31:0] r_d;
    int          r_a;

    initial begin
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_shift_out", shift_out, 0);
        chk("rst_carry_out", carry_out, 0);
        chk("rst_in_ready", in_ready, 0);
`ifdef ARM_SHIFT_PIPE_FLAGS_EN
        chk("rst_zero", zero_out, 0);
        chk("rst_neg", neg_out, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // latency: out_valid rises exactly P edges after the accepting edge
        send(1, 2'd0, 32'hF000_000F, 4, 0, {1'b1, 32'h0000_00F0}, "imm_lsl4");
        for (int i = 0; i < P; i++) begin
            chk("lat_early", out_valid, 0);
            @(negedge clk);
        end
        chk("lat_on_time", out_valid, 1);
        drain("lat");

        send(0, 2'd1, 32'h8000_0001, 32, 0, {1'b1, 32'h0}, "reg_lsr32");
        send(0, 2'd1, 32'h8000_0001, 33, 1, {1'b0, 32'h0}, "reg_lsr33");
        send(0, 2'd1, 32'h8000_0001, 0, 1, {1'b1, 32'h8000_0001}, "reg_lsr0");
        send(1, 2'd3, 32'h0000_0003, 0, 1, {1'b1, 32'h8000_0001}, "imm_rrx");
        send(0, 2'd3, 32'h0000_00F1, 36, 1, {1'b0, 32'h1000_000F}, "reg_ror36");
        send(0, 2'd3, 32'h8000_0000, 64, 0, {1'b1, 32'h8000_0000}, "reg_ror64");
        send(0, 2'd2, 32'h8000_0000, 40, 0, {1'b1, 32'hFFFF_FFFF}, "reg_asr40");
        send(0, 2'd0, 32'h1234_5678, 40, 1, {1'b0, 32'h0}, "reg_lsl40");
        send(1, 2'd1, 32'h8000_0001, 32, 0, {1'b1, 32'h0}, "imm_lsr0_via_upper");
        send(1, 2'd2, 32'h7000_0000, 0, 1, {1'b0, 32'h0}, "imm_asr0_pos");
        drain("directed");

        // backpressure: out_ready toggles every cycle
        tog_en = 1'b1;
        for (int i = 1; i <= 8; i++)
            send(1, 2'd0, 32'(i), 1, 0, {1'b0, 32'(2 * i)}, "bp_lsl1");
        drain("bp");

        for (int i = 0; i < 40; i++) begin
            r_imm = 1'($urandom_range(0, 1));
            r_op  = 2'($urandom_range(0, 3));
            r_d   = $urandom;
            r_cin = 1'($urandom_range(0, 1));
            r_a   = (i % 2 == 1) ? amts[$urandom_range(0, 7)] : int'($urandom_range(0, 255));
            send(r_imm, r_op, r_d, r_a, r_cin, model(r_imm, r_op, r_d, r_a, r_cin), "rand");
        end
        drain("rand");
        tog_en = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);

        // reset with two operations in flight: both must vanish
        send(0, 2'd0, 32'h0000_0001, 3, 0, {1'b0, 32'h8}, "flight0");
        send(0, 2'd0, 32'h0000_0002, 3, 0, {1'b0, 32'h10}, "flight1");
        rst = 1'b1;
        sb_q.delete();
        tag_q.delete();
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_shift_out", shift_out, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        for (int i = 0; i < P + 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_valid", out_valid, 0);
        end

        send(0, 2'd2, 32'h8000_0010, 4, 0, {1'b0, 32'hF800_0001}, "post_rst_asr4");
        drain("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
